// File: rtl/ram_arbiter.sv
// Arbiter sharing one synchronous-read data RAM between the CPU port and the debug/loader port.
// Build option ARB_DBG_PRIORITY_EN: debug port always wins a tie instead of round-robin.
module ram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    // Requester handshake: req (with we/addr/wdata) is the valid side and is held until the
    // clock edge that samples gnt=1; gnt is the one-cycle ready/accept pulse. Reads then return
    // data on rdata qualified by a one-cycle rvalid pulse in the cycle after gnt.
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              ram_w_en,
    output logic [ADDR_W-1:0] ram_r_addr,
    output logic [ADDR_W-1:0] ram_w_addr,
    output logic [DATA_W-1:0] ram_w_data,
    input  logic [DATA_W-1:0] ram_r_data,
    output logic              busy,
    output logic [1:0]        o_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_src;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
`ifndef ARB_DBG_PRIORITY_EN
    logic              r_last_dbg;
`endif

    logic              w_pick_dbg;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    // On a tie the port that did not win the previous arbitration is chosen.
    always_comb begin
`ifdef ARB_DBG_PRIORITY_EN
        w_pick_dbg = dbg_req;
`else
        w_pick_dbg = dbg_req & (~cpu_req | ~r_last_dbg);
`endif
        w_sel_we    = w_pick_dbg ? dbg_we    : cpu_we;
        w_sel_addr  = w_pick_dbg ? dbg_addr  : cpu_addr;
        w_sel_wdata = w_pick_dbg ? dbg_wdata : cpu_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_src      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
`ifndef ARB_DBG_PRIORITY_EN
            r_last_dbg <= 1'b1;
`endif
            cpu_gnt    <= 1'b0;
            dbg_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
            ram_w_en   <= 1'b0;
        end else begin
            cpu_gnt    <= 1'b0;
            dbg_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
            ram_w_en   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cpu_req || dbg_req) begin
                        r_src      <= w_pick_dbg;
                        r_we       <= w_sel_we;
                        r_addr     <= w_sel_addr;
                        r_wdata    <= w_sel_wdata;
`ifndef ARB_DBG_PRIORITY_EN
                        r_last_dbg <= w_pick_dbg;
`endif
                        cpu_gnt    <= ~w_pick_dbg;
                        dbg_gnt    <= w_pick_dbg;
                        ram_w_en   <= w_sel_we;
                        r_state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Writes complete here; reads wait one cycle for the RAM's registered output.
                    if (r_we) begin
                        r_state <= IDLE;
                    end else begin
                        cpu_rvalid <= ~r_src;
                        dbg_rvalid <= r_src;
                        r_state    <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ram_r_addr = r_addr;
    assign ram_w_addr = r_addr;
    assign ram_w_data = r_wdata;
    assign cpu_rdata  = cpu_rvalid ? ram_r_data : '0;
    assign dbg_rdata  = dbg_rvalid ? ram_r_data : '0;
    assign busy       = (r_state != IDLE);
    assign o_state    = r_state;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: transaction-schedule model, RAM model, directed and random traffic.
module tb_ram_arbiter;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [7:0]  cpu_addr, dbg_addr;
    logic [15:0] cpu_wdata, dbg_wdata;
    logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [15:0] cpu_rdata, dbg_rdata;
    logic        ram_w_en;
    logic [7:0]  ram_r_addr, ram_w_addr;
    logic [15:0] ram_w_data, ram_r_data;
    logic        busy;
    logic [1:0]  o_state;

    ram_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .ram_w_en(ram_w_en), .ram_r_addr(ram_r_addr), .ram_w_addr(ram_w_addr),
        .ram_w_data(ram_w_data), .ram_r_data(ram_r_data),
        .busy(busy), .o_state(o_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- RAM: synchronous read, data valid the cycle after the address ----------------
    logic [15:0] ram_mem [256];
    always @(posedge clk) begin
        if (ram_w_en) ram_mem[ram_w_addr] <= ram_w_data;
        ram_r_data <= ram_mem[ram_r_addr];
    end

    // ---------------- counters and check helper ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // ---------------- behavioural model: a schedule of what each cycle must show ----------------
    logic [15:0] model_mem [256];
    int          m_edge, m_free_at, m_resp_edge;
    bit          m_resp_dbg, m_last_dbg, m_wr_pend;
    bit          m_gnt_cpu, m_gnt_dbg, m_wen, m_rv_cpu, m_rv_dbg, m_busy;
    logic [7:0]  m_addr;
    logic [15:0] m_wdata;
    logic [15:0] cpu_exp_q[$];
    logic [15:0] dbg_exp_q[$];

    task automatic model_reset();
        m_edge = 0; m_free_at = 0; m_resp_edge = -1; m_resp_dbg = 0;
        m_last_dbg = 1; m_wr_pend = 0;
        m_gnt_cpu = 0; m_gnt_dbg = 0; m_wen = 0; m_rv_cpu = 0; m_rv_dbg = 0; m_busy = 0;
        m_addr = '0; m_wdata = '0;
        cpu_exp_q.delete();
        dbg_exp_q.delete();
    endtask

    task automatic model_step();
        bit pick_dbg;
        bit we;
        m_edge++;
        if (m_wr_pend) begin
            model_mem[m_addr] = m_wdata;
            m_wr_pend = 0;
        end
        m_gnt_cpu = 0; m_gnt_dbg = 0; m_wen = 0; m_rv_cpu = 0; m_rv_dbg = 0;
        if (m_edge == m_resp_edge) begin
            if (m_resp_dbg) m_rv_dbg = 1;
            else            m_rv_cpu = 1;
        end
        if (m_edge >= m_free_at && (cpu_req || dbg_req)) begin
`ifdef ARB_DBG_PRIORITY_EN
            pick_dbg = dbg_req;
`else
            if (cpu_req && dbg_req) pick_dbg = !m_last_dbg;
            else                    pick_dbg = dbg_req;
`endif
            m_last_dbg = pick_dbg;
            we      = pick_dbg ? dbg_we    : cpu_we;
            m_addr  = pick_dbg ? dbg_addr  : cpu_addr;
            m_wdata = pick_dbg ? dbg_wdata : cpu_wdata;
            m_gnt_dbg = pick_dbg;
            m_gnt_cpu = !pick_dbg;
            m_wen     = we;
            if (we) begin
                m_wr_pend = 1;
                m_free_at = m_edge + 2;
            end else begin
                m_resp_edge = m_edge + 1;
                m_resp_dbg  = pick_dbg;
                m_free_at   = m_edge + 3;
                if (pick_dbg) dbg_exp_q.push_back(model_mem[m_addr]);
                else          cpu_exp_q.push_back(model_mem[m_addr]);
            end
        end
        m_busy = (m_edge + 1 < m_free_at);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // ---------------- compare process (mid-cycle, away from the active edge) ----------------
    bit          grant_q[$];
    int          mon_w_cyc;
    logic [7:0]  mon_w_addr;
    logic [15:0] mon_w_data;

    initial forever begin
        @(negedge clk);
        chk("cpu_gnt",    cpu_gnt,    m_gnt_cpu);
        chk("dbg_gnt",    dbg_gnt,    m_gnt_dbg);
        chk("cpu_rvalid", cpu_rvalid, m_rv_cpu);
        chk("dbg_rvalid", dbg_rvalid, m_rv_dbg);
        chk("ram_w_en",   ram_w_en,   m_wen);
        chk("ram_r_addr", ram_r_addr, m_addr);
        chk("ram_w_addr", ram_w_addr, m_addr);
        chk("ram_w_data", ram_w_data, m_wdata);
        chk("busy",       busy,       m_busy);
        chk("gnt_onehot",    cpu_gnt & dbg_gnt, 0);
        chk("rvalid_onehot", cpu_rvalid & dbg_rvalid, 0);
        if (m_rv_cpu && cpu_exp_q.size() > 0) chk("cpu_rdata", cpu_rdata, cpu_exp_q.pop_front());
        if (m_rv_dbg && dbg_exp_q.size() > 0) chk("dbg_rdata", dbg_rdata, dbg_exp_q.pop_front());
        if (cpu_gnt) grant_q.push_back(1'b0);
        if (dbg_gnt) grant_q.push_back(1'b1);
        if (ram_w_en) begin
            mon_w_cyc  = cyc;
            mon_w_addr = ram_w_addr;
            mon_w_data = ram_w_data;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_port(input bit port, input bit req, input bit we,
                            input logic [7:0] a, input logic [15:0] d);
        if (port) begin
            dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d;
        end else begin
            cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        end
    endtask

    // port 0 = CPU, 1 = debug; returns the cycle of gnt and, for reads, the data seen with rvalid
    task automatic do_xact(input bit port, input bit we, input logic [7:0] a, input logic [15:0] d,
                           input bit jitter, output int gcyc, output logic [15:0] rd, output bit rv);
        int n;
        bit g;
        set_port(port, 1'b1, we, a, d);
        n = 0;
        g = 0;
        while (!g && n < 2000) begin
            @(negedge clk);
            n++;
            g = port ? dbg_gnt : cpu_gnt;
            if (!g && jitter && $urandom_range(0, 3) == 0)
                set_port(port, 1'b1, we, 8'($urandom_range(0, 15)), 16'($urandom));
        end
        chk("gnt_wait", g, 1);
        gcyc = cyc;
        rv = 0;
        rd = '0;
        if (!g) begin
            set_port(port, 1'b0, we, a, d);
        end else begin
            @(posedge clk);
            #1 set_port(port, 1'b0, we, a, d);
            if (!we) begin
                @(negedge clk);
                rv = port ? dbg_rvalid : cpu_rvalid;
                rd = port ? dbg_rdata  : cpu_rdata;
            end
        end
    endtask

    task automatic rand_traffic(input bit port, input int count);
        int gc;
        logic [15:0] rd;
        bit rv;
        for (int i = 0; i < count; i++) begin
            do_xact(port, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom), 1'b1,
                    gc, rd, rv);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    int          s, g_c, g_d, n_wait;
    logic [15:0] rd_c, rd_d;
    bit          rv_c, rv_d;
    bit          exp_order[8];

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_mem[i]   = '0;
            model_mem[i] = '0;
        end
        rst_n = 1'b0;
        set_port(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        set_port(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        repeat (3) @(negedge clk);

        // reset values
        chk("rst_cpu_gnt",    cpu_gnt,    0);
        chk("rst_dbg_gnt",    dbg_gnt,    0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_dbg_rvalid", dbg_rvalid, 0);
        chk("rst_ram_w_en",   ram_w_en,   0);
        chk("rst_ram_r_addr", ram_r_addr, 0);
        chk("rst_ram_w_data", ram_w_data, 0);
        chk("rst_cpu_rdata",  cpu_rdata,  0);
        chk("rst_dbg_rdata",  dbg_rdata,  0);
        chk("rst_busy",       busy,       0);
        rst_n = 1'b1;
        @(negedge clk);

        // CPU write 0x10 <= 0xBEEF, then read it back
        s = cyc;
        do_xact(1'b0, 1'b1, 8'h10, 16'hBEEF, 1'b0, g_c, rd_c, rv_c);
        chk("t1_gnt_latency", g_c - s, 1);
        chk("t1_w_cycle",     mon_w_cyc, g_c);
        chk("t1_w_addr",      mon_w_addr, 8'h10);
        chk("t1_w_data",      mon_w_data, 16'hBEEF);
        do_xact(1'b0, 1'b0, 8'h10, 16'h0000, 1'b0, g_c, rd_c, rv_c);
        chk("t1_rvalid", rv_c, 1);
        chk("t1_rdata",  rd_c, 16'hBEEF);

        // simultaneous reads right after reset
        do_xact(1'b0, 1'b1, 8'h01, 16'h1111, 1'b0, g_c, rd_c, rv_c);
        do_xact(1'b1, 1'b1, 8'h02, 16'h2222, 1'b0, g_d, rd_d, rv_d);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        fork
            do_xact(1'b0, 1'b0, 8'h01, 16'h0000, 1'b0, g_c, rd_c, rv_c);
            do_xact(1'b1, 1'b0, 8'h02, 16'h0000, 1'b0, g_d, rd_d, rv_d);
        join
`ifdef ARB_DBG_PRIORITY_EN
        chk("t2_gnt_spacing", g_c - g_d, 3);
`else
        chk("t2_gnt_spacing", g_d - g_c, 3);
`endif
        chk("t2_cpu_rvalid", rv_c, 1);
        chk("t2_dbg_rvalid", rv_d, 1);
        chk("t2_cpu_rdata",  rd_c, 16'h1111);
        chk("t2_dbg_rdata",  rd_d, 16'h2222);

        // continuous back-to-back writes from both ports
        @(negedge clk);
        grant_q.delete();
        fork
            for (int i = 0; i < 4; i++) do_xact(1'b0, 1'b1, 8'(8'h20 + i), 16'(16'hC000 + i), 1'b0, g_c, rd_c, rv_c);
            for (int i = 0; i < 4; i++) do_xact(1'b1, 1'b1, 8'(8'h30 + i), 16'(16'hD000 + i), 1'b0, g_d, rd_d, rv_d);
        join
        for (int i = 0; i < 8; i++) begin
`ifdef ARB_DBG_PRIORITY_EN
            exp_order[i] = (i < 4);
`else
            exp_order[i] = (i % 2 == 1);
`endif
        end
        chk("t3_grant_count", grant_q.size(), 8);
        for (int i = 0; i < 8 && i < grant_q.size(); i++) chk("t3_grant_order", grant_q[i], exp_order[i]);

        // debug read issued while a CPU write is in ACCESS
        @(negedge clk);
        fork
            do_xact(1'b0, 1'b1, 8'h40, 16'h4444, 1'b0, g_c, rd_c, rv_c);
            begin
                n_wait = 0;
                do begin
                    @(negedge clk);
                    n_wait++;
                end while (!cpu_gnt && n_wait < 20);
                chk("t4_cpu_gnt_seen", cpu_gnt, 1);
                chk("t4_busy_access", busy, 1);
                do_xact(1'b1, 1'b0, 8'h40, 16'h0000, 1'b0, g_d, rd_d, rv_d);
            end
        join
        chk("t4_dbg_gnt_delay", g_d - g_c, 2);
        chk("t4_dbg_rdata", rd_d, 16'h4444);

        // reset during ACCESS of a CPU write
        @(negedge clk);
        set_port(1'b0, 1'b1, 1'b1, 8'h50, 16'h5555);
        n_wait = 0;
        do begin
            @(negedge clk);
            n_wait++;
        end while (!cpu_gnt && n_wait < 20);
        chk("t5_w_en_before", ram_w_en, 1);
        #1;
        rst_n = 1'b0;
        set_port(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        #1;
        chk("t5_w_en_async", ram_w_en, 0);
        chk("t5_gnt_async",  cpu_gnt,  0);
        chk("t5_busy_async", busy,     0);
        @(negedge clk);
        rst_n = 1'b1;
        fork
            do_xact(1'b0, 1'b0, 8'h01, 16'h0000, 1'b0, g_c, rd_c, rv_c);
            do_xact(1'b1, 1'b0, 8'h02, 16'h0000, 1'b0, g_d, rd_d, rv_d);
        join
`ifdef ARB_DBG_PRIORITY_EN
        chk("t5_tie_winner", g_c - g_d, 3);
`else
        chk("t5_tie_winner", g_d - g_c, 3);
`endif
        do_xact(1'b0, 1'b0, 8'h50, 16'h0000, 1'b0, g_c, rd_c, rv_c);
        chk("t5_aborted_write", rd_c, 16'h0000);

        // randomized traffic from both ports
        fork
            rand_traffic(1'b0, 120);
            rand_traffic(1'b1, 120);
        join

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
